led_pattern_monitor: RTL and testbench

Receive-side checker for the 12-LED rotating-pattern bus. It samples a 12-bit LED word and filters out glitches and transitions. Each stable word is decoded back to a rotation step of the base sequence. The block verifies that successive steps advance by one modulo 12, and reports lock status, sequence errors and, optionally, step dwell time. It sits on the board-test loopback path: the LED driver's output bus feeds `led_in`, and the status outputs go to the debug header or to a host register.

---
 rtl/led_pattern_monitor.sv | 164 ++++++++++++++++
 tb/tb_led_pattern_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_monitor.sv
// rtl/led_pattern_monitor.sv - receive-side checker for the 12-LED rotating-pattern bus
// Optional dwell-time measurement is enabled by defining LED_PATTERN_MONITOR_DWELL_EN.
module led_pattern_monitor #(
    parameter logic [11:0] BASE_SEQ      = 12'b000011101101,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] led_in,
    output logic [3:0]  step,
    output logic        step_valid,
    output logic        polarity,
    output logic        locked,
    output logic        seq_err,
    output logic [7:0]  err_count,
    output logic [27:0] dwell
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_TRACK,
        ST_LOCKED
    } state_t;

    state_t      state;
    logic [11:0] s;
    logic [7:0]  cnt;
    logic        accept;
    logic        dec_known;
    logic        dec_pol;
    logic [3:0]  dec_step;
    logic [3:0]  step_next;

    function automatic logic [11:0] rotl12(input logic [11:0] x, input int k);
        logic [23:0] d;
        d = {x, x} << k;
        return d[23:12];
    endfunction

    // accept fires exactly once per stable word; the saturated count blocks re-fire
    assign accept    = (led_in == s) && (cnt == CNT_ACC);
    assign step_next = (step == 4'd11) ? 4'd0 : step + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s   <= '0;
            cnt <= '0;
        end else begin
            s <= led_in;
            if (led_in != s) begin
                cnt <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Scan from the top so the lowest k and polarity 0 take priority.
    always_comb begin
        logic [11:0] r;
        dec_known = 1'b0;
        dec_pol   = 1'b0;
        dec_step  = '0;
        r         = '0;
        for (int k = 11; k >= 0; k--) begin
            r = rotl12(BASE_SEQ, k);
            if (s == ~r) begin
                dec_known = 1'b1;
                dec_pol   = 1'b1;
                dec_step  = 4'(k);
            end
            if (s == r) begin
                dec_known = 1'b1;
                dec_pol   = 1'b0;
                dec_step  = 4'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_SEARCH;
            step       <= '0;
            step_valid <= 1'b0;
            polarity   <= 1'b0;
            locked     <= 1'b0;
            seq_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            seq_err <= 1'b0;
            if (accept) begin
                case (state)
                    ST_SEARCH: begin
                        if (dec_known) begin
                            step       <= dec_step;
                            polarity   <= dec_pol;
                            step_valid <= 1'b1;
                            state      <= ST_TRACK;
                        end
                    end
                    ST_TRACK: begin
                        if (!dec_known) begin
                            step_valid <= 1'b0;
                            state      <= ST_SEARCH;
                        end else begin
                            step     <= dec_step;
                            polarity <= dec_pol;
                            if (dec_step == step_next) begin
                                locked <= 1'b1;
                                state  <= ST_LOCKED;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (!dec_known || (dec_step != step_next)) begin
                            seq_err <= 1'b1;
                            locked  <= 1'b0;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end
                        if (!dec_known) begin
                            step_valid <= 1'b0;
                            state      <= ST_SEARCH;
                        end else begin
                            step     <= dec_step;
                            polarity <= dec_pol;
                            if (dec_step != step_next) begin
                                state <= ST_TRACK;
                            end
                        end
                    end
                    default: state <= ST_SEARCH;
                endcase
            end
        end
    end

`ifdef LED_PATTERN_MONITOR_DWELL_EN
    localparam logic [27:0] DWELL_MAX = '1;

    logic [27:0] dwell_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
            dwell     <= '0;
        end else if (accept) begin
            dwell_cnt <= '0;
            if (state != ST_SEARCH) begin
                dwell <= (dwell_cnt == DWELL_MAX) ? DWELL_MAX : dwell_cnt + 28'd1;
            end
        end else if (dwell_cnt != DWELL_MAX) begin
            dwell_cnt <= dwell_cnt + 28'd1;
        end
    end
`else
    assign dwell = '0;
`endif

endmodule

// File: tb/tb_led_pattern_monitor.sv
// tb/tb_led_pattern_monitor.sv - self-checking bench for led_pattern_monitor
module tb_led_pattern_monitor;

    localparam logic [11:0] BASE = 12'b000011101101;

    logic        clk;
    logic        rst_n;
    logic [11:0] led_in;
    logic [3:0]  step;
    logic        step_valid;
    logic        polarity;
    logic        locked;
    logic        seq_err;
    logic [7:0]  err_count;
    logic [27:0] dwell;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] step;
        logic       valid;
        logic       pol;
        logic       lock;
        int         pulses;
        logic [7:0] errc;
    } exp_t;

    exp_t sb[$];

    led_pattern_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .led_in     (led_in),
        .step       (step),
        .step_valid (step_valid),
        .polarity   (polarity),
        .locked     (locked),
        .seq_err    (seq_err),
        .err_count  (err_count),
        .dwell      (dwell)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog expired got timeout exp finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] pat(input int k, input bit inv);
        logic [11:0] r;
        r = BASE;
        for (int i = 0; i < k; i++) r = {r[10:0], r[11]};
        return inv ? ~r : r;
    endfunction

    task automatic edge1();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_word(input string tag, input logic [11:0] w, input int n,
                            input logic [3:0] es, input logic ev, input logic ep,
                            input logic el, input int epul, input logic [7:0] ec);
        exp_t e;
        int   pul;
        e.step = es; e.valid = ev; e.pol = ep; e.lock = el; e.pulses = epul; e.errc = ec;
        sb.push_back(e);
        pul = 0;
        led_in = w;
        repeat (n) begin
            edge1();
            if (seq_err === 1'b1) pul++;
        end
        e = sb.pop_front();
        checks++;
        if (step_valid !== e.valid) begin
            errors++;
            $display("FAIL %s step_valid got %0b exp %0b", tag, step_valid, e.valid);
        end
        checks++;
        if (locked !== e.lock) begin
            errors++;
            $display("FAIL %s locked got %0b exp %0b", tag, locked, e.lock);
        end
        checks++;
        if (err_count !== e.errc) begin
            errors++;
            $display("FAIL %s err_count got %0d exp %0d", tag, err_count, e.errc);
        end
        checks++;
        if (pul != e.pulses) begin
            errors++;
            $display("FAIL %s seq_err_cycles got %0d exp %0d", tag, pul, e.pulses);
        end
        if (e.valid) begin
            checks++;
            if (step !== e.step) begin
                errors++;
                $display("FAIL %s step got %0d exp %0d", tag, step, e.step);
            end
            checks++;
            if (polarity !== e.pol) begin
                errors++;
                $display("FAIL %s polarity got %0b exp %0b", tag, polarity, e.pol);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({step, step_valid, polarity, locked, seq_err, err_count, dwell} !== '0) begin
            errors++;
            $display("FAIL %s outputs got step=%0d v=%0b p=%0b l=%0b e=%0b ec=%0d dw=%0d exp all 0",
                     tag, step, step_valid, polarity, locked, seq_err, err_count, dwell);
        end
    endtask

    task automatic check_latency(input string tag, input logic [3:0] es, input logic ep);
        for (int i = 1; i <= 4; i++) begin
            edge1();
            checks++;
            if (step_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s early_valid_edge%0d got %0b exp 0", tag, i, step_valid);
            end
        end
        edge1();
        checks++;
        if (step_valid !== 1'b1 || step !== es || polarity !== ep || locked !== 1'b0) begin
            errors++;
            $display("FAIL %s accept_e5 got v=%0b s=%0d p=%0b l=%0b exp v=1 s=%0d p=%0b l=0",
                     tag, step_valid, step, polarity, locked, es, ep);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        led_in = '0;
        repeat (2) edge1();
        check_zero("reset");
        rst_n = 1'b1;
        repeat (6) edge1();
        check_zero("idle_zero_word");
    endtask

    task automatic test_clean();
        led_in = pat(0, 1);
        check_latency("clean_first", 4'd0, 1'b1);
        repeat (5) edge1();
        for (int k = 1; k < 12; k++) begin
            run_word("clean", pat(k, 1), 10, 4'(k), 1'b1, 1'b1, 1'b1, 0, 8'd0);
        end
    endtask

    task automatic test_wrap();
        run_word("wrap", pat(0, 1), 10, 4'd0, 1'b1, 1'b1, 1'b1, 0, 8'd0);
        run_word("pol_change", pat(1, 0), 10, 4'd1, 1'b1, 1'b0, 1'b1, 0, 8'd0);
    endtask

    task automatic test_glitch();
        run_word("to_step2", pat(2, 0), 10, 4'd2, 1'b1, 1'b0, 1'b1, 0, 8'd0);
        run_word("to_step3", pat(3, 0), 10, 4'd3, 1'b1, 1'b0, 1'b1, 0, 8'd0);
        run_word("glitch", pat(7, 0), 3, 4'd3, 1'b1, 1'b0, 1'b1, 0, 8'd0);
        run_word("after_glitch", pat(4, 0), 10, 4'd4, 1'b1, 1'b0, 1'b1, 0, 8'd0);
    endtask

    task automatic test_skip_unknown();
        for (int j = 0; j < 10; j++) begin
            run_word("walk", pat((5 + j) % 12, 0), 6, 4'((5 + j) % 12), 1'b1, 1'b0, 1'b1, 0, 8'd0);
        end
        run_word("skip", pat(5, 0), 10, 4'd5, 1'b1, 1'b0, 1'b0, 1, 8'd1);
        run_word("relock6", pat(6, 0), 10, 4'd6, 1'b1, 1'b0, 1'b1, 0, 8'd1);
        run_word("relock7", pat(7, 0), 10, 4'd7, 1'b1, 1'b0, 1'b1, 0, 8'd1);
        run_word("unknown", 12'b000111111111, 10, 4'd0, 1'b0, 1'b0, 1'b0, 1, 8'd2);
        run_word("zero_search", 12'h000, 10, 4'd0, 1'b0, 1'b0, 1'b0, 0, 8'd2);
    endtask

    task automatic test_saturation();
        int k;
        int kn;
        int kw;
        int ec;
        k  = 0;
        ec = 2;
        run_word("sat_start", pat(0, 0), 5, 4'd0, 1'b1, 1'b0, 1'b0, 0, 8'(ec));
        for (int i = 0; i < 260; i++) begin
            kn = (k + 1) % 12;
            run_word("sat_lock", pat(kn, 0), 5, 4'(kn), 1'b1, 1'b0, 1'b1, 0, 8'(ec));
            kw = (kn + 3) % 12;
            if (ec < 255) ec++;
            run_word("sat_err", pat(kw, 0), 5, 4'(kw), 1'b1, 1'b0, 1'b0, 1, 8'(ec));
            k = kw;
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_final err_count got %0d exp 255", err_count);
        end
        kn = (k + 1) % 12;
        led_in = pat(kn, 0);
        repeat (2) edge1();
        rst_n = 1'b0;
        edge1();
        rst_n = 1'b1;
        check_zero("mid_word_reset");
        check_latency("post_reset", 4'(kn), 1'b0);
    endtask

    task automatic test_dwell();
        logic [27:0] exp_dw;
`ifdef LED_PATTERN_MONITOR_DWELL_EN
        exp_dw = 28'd100;
`else
        exp_dw = 28'd0;
`endif
        led_in = '0;
        rst_n  = 1'b0;
        edge1();
        rst_n = 1'b1;
        run_word("dwell_a", pat(0, 0), 100, 4'd0, 1'b1, 1'b0, 1'b0, 0, 8'd0);
        checks++;
        if (dwell !== 28'd0) begin
            errors++;
            $display("FAIL dwell_first got %0d exp 0", dwell);
        end
        run_word("dwell_b", pat(1, 0), 100, 4'd1, 1'b1, 1'b0, 1'b1, 0, 8'd0);
        checks++;
        if (dwell !== exp_dw) begin
            errors++;
            $display("FAIL dwell_second got %0d exp %0d", dwell, exp_dw);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        led_in = '0;
        @(negedge clk);
        test_reset();
        test_clean();
        test_wrap();
        test_glitch();
        test_skip_unknown();
        test_saturation();
        test_dwell();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
